// File: rtl/pong_pkg.sv
// Shared types for the Pong match controller: FSM states, player IDs, serve directions.
// No logic; imported by the controller and its frame timer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    RUNNING,
    POINT_P1,
    POINT_P2,
    MATCH_OVER
  } state_t;

  typedef enum logic {
    PLAYER_1 = 1'b0,
    PLAYER_2 = 1'b1
  } player_t;

  localparam logic SERVE_TO_P1 = 1'b0;
  localparam logic SERVE_TO_P2 = 1'b1;

endpackage

// File: rtl/pong_frame_timer.sv
// VSync rising-edge detector plus serve-delay frame counter; done is combinational on the counting tick.
// Latency: done asserts in the cycle the SERVE_FRAMES-th tick is seen; no backpressure, clear holds count at 0.
module pong_frame_timer
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_VSync,
  input  logic clear,
  output logic done
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((SERVE_FRAMES > 0) ? SERVE_FRAMES - 1 : 0);

  logic             vsync_q;
  logic             frame_tick;
  logic [CNT_W-1:0] frame_cnt;

  // Edge history keeps tracking during reset so a level held across reset is not a fresh edge.
  always_ff @(posedge i_Clk) begin
    vsync_q <= i_VSync;
  end

  assign frame_tick = i_VSync & ~vsync_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || clear) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign done = (SERVE_FRAMES == 0) || (frame_tick && (frame_cnt == LAST_CNT));

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match FSM: miss detection, scoring, serve delay, match end with latched winner.
// Latency: miss at N -> o_Game_Active low N+1, o_Point/score N+2; no backpressure, inputs sampled every cycle.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int POS_W         = 6,
  parameter int SCORE_LIMIT   = 9,
  parameter int SCORE_W       = 4,
  parameter int SERVE_FRAMES  = 60,
  parameter int AUTO_SERVE    = 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_VSync,
  input  logic               i_Game_Start,
  input  logic [POS_W-1:0]   i_Ball_X,
  input  logic [POS_W-1:0]   i_Ball_Y,
  input  logic [POS_W-1:0]   i_Paddle_Y_P1,
  input  logic [POS_W-1:0]   i_Paddle_Y_P2,
  output logic               o_Game_Active,
  output logic [SCORE_W-1:0] o_P1_Score,
  output logic [SCORE_W-1:0] o_P2_Score,
  output logic               o_Serve_Dir,
  output logic               o_Point,
  output logic               o_Match_Over,
  output logic               o_Winner
);

  localparam int CMP_W = POS_W + 1;
  localparam logic [POS_W-1:0]   P2_COL    = POS_W'(GAME_WIDTH - 1);
  localparam logic [CMP_W-1:0]   PAD_SPAN  = CMP_W'(PADDLE_HEIGHT - 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(SCORE_LIMIT);

  if (GAME_WIDTH < 1 || GAME_WIDTH > (1 << POS_W) || GAME_HEIGHT < 1 ||
      GAME_HEIGHT > (1 << POS_W) || SCORE_LIMIT < 1 || SCORE_LIMIT >= (1 << SCORE_W)) begin : g_param_check
    $error("pong_match_ctrl: board or score parameter out of range");
  end

  state_t             state;
  logic               start_q;
  logic               start_edge;
  logic               serve_done;
  logic               miss_p1;
  logic               miss_p2;
  logic [CMP_W-1:0]   ball_y_ext;
  logic [CMP_W-1:0]   p1_top;
  logic [CMP_W-1:0]   p2_top;
  logic [CMP_W-1:0]   p1_bot;
  logic [CMP_W-1:0]   p2_bot;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;

  always_ff @(posedge i_Clk) begin
    start_q <= i_Game_Start;
  end

  assign start_edge = i_Game_Start & ~start_q;

  pong_frame_timer #(
    .SERVE_FRAMES (SERVE_FRAMES)
  ) u_frame_timer (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_VSync (i_VSync),
    .clear   (state != SERVE_WAIT),
    .done    (serve_done)
  );

  // One extra bit so a paddle near the bottom edge never wraps its last row back to the top.
  assign ball_y_ext = {1'b0, i_Ball_Y};
  assign p1_top     = {1'b0, i_Paddle_Y_P1};
  assign p2_top     = {1'b0, i_Paddle_Y_P2};
  assign p1_bot     = p1_top + PAD_SPAN;
  assign p2_bot     = p2_top + PAD_SPAN;

  assign miss_p1 = (i_Ball_X == '0)     && ((ball_y_ext < p1_top) || (ball_y_ext > p1_bot));
  assign miss_p2 = (i_Ball_X == P2_COL) && ((ball_y_ext < p2_top) || (ball_y_ext > p2_bot));

  assign p1_next = o_P1_Score + 1'b1;
  assign p2_next = o_P2_Score + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= IDLE;
      o_Game_Active <= 1'b0;
      o_P1_Score    <= '0;
      o_P2_Score    <= '0;
      o_Serve_Dir   <= SERVE_TO_P2;
      o_Point       <= 1'b0;
      o_Match_Over  <= 1'b0;
      o_Winner      <= PLAYER_1;
    end else begin
      o_Point <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_edge) state <= SERVE_WAIT;
        end
        SERVE_WAIT: begin
          if (serve_done) begin
            state         <= RUNNING;
            o_Game_Active <= 1'b1;
          end
        end
        RUNNING: begin
          // Only reachable together when the board is one column wide; P1's miss wins.
          if (miss_p1) begin
            state         <= POINT_P2;
            o_Game_Active <= 1'b0;
          end else if (miss_p2) begin
            state         <= POINT_P1;
            o_Game_Active <= 1'b0;
          end
        end
        POINT_P1: begin
          o_P1_Score  <= p1_next;
          o_Point     <= 1'b1;
          o_Serve_Dir <= SERVE_TO_P2;
          if (p1_next == WIN_SCORE) begin
            state        <= MATCH_OVER;
            o_Match_Over <= 1'b1;
            o_Winner     <= PLAYER_1;
          end else begin
            state <= (AUTO_SERVE != 0) ? SERVE_WAIT : IDLE;
          end
        end
        POINT_P2: begin
          o_P2_Score  <= p2_next;
          o_Point     <= 1'b1;
          o_Serve_Dir <= SERVE_TO_P1;
          if (p2_next == WIN_SCORE) begin
            state        <= MATCH_OVER;
            o_Match_Over <= 1'b1;
            o_Winner     <= PLAYER_2;
          end else begin
            state <= (AUTO_SERVE != 0) ? SERVE_WAIT : IDLE;
          end
        end
        MATCH_OVER: begin
          if (start_edge) begin
            state        <= SERVE_WAIT;
            o_P1_Score   <= '0;
            o_P2_Score   <= '0;
            o_Match_Over <= 1'b0;
            o_Serve_Dir  <= SERVE_TO_P2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomized rally bench for pong_match_ctrl against a point/score model kept at the rules level.
module tb_pong_match_ctrl;

  localparam int GW     = 40;
  localparam int PH     = 6;
  localparam int LIMIT  = 3;
  localparam int FRAMES = 3;
  localparam int MID_X  = 20;

  logic       clk = 1'b0;
  logic       rst, vsync, start;
  logic [5:0] ball_x, ball_y, pad1, pad2;
  logic       active, point, serve_dir, over, winner;
  logic [3:0] p1_score, p2_score;

  logic       m_rst, m_start;
  logic [5:0] m_x, m_y, m_pad1, m_pad2;
  logic       m_active, m_point, m_serve_dir, m_over, m_winner;
  logic [3:0] m_p1_score, m_p2_score;

  int n_vec = 0;
  int n_bad = 0;
  int exp_p1, exp_p2, exp_serve;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .GAME_WIDTH(GW), .GAME_HEIGHT(30), .PADDLE_HEIGHT(PH), .POS_W(6),
    .SCORE_LIMIT(LIMIT), .SCORE_W(4), .SERVE_FRAMES(FRAMES), .AUTO_SERVE(1)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_VSync(vsync), .i_Game_Start(start),
    .i_Ball_X(ball_x), .i_Ball_Y(ball_y), .i_Paddle_Y_P1(pad1), .i_Paddle_Y_P2(pad2),
    .o_Game_Active(active), .o_P1_Score(p1_score), .o_P2_Score(p2_score),
    .o_Serve_Dir(serve_dir), .o_Point(point), .o_Match_Over(over), .o_Winner(winner)
  );

  pong_match_ctrl #(
    .GAME_WIDTH(GW), .GAME_HEIGHT(30), .PADDLE_HEIGHT(PH), .POS_W(6),
    .SCORE_LIMIT(LIMIT), .SCORE_W(4), .SERVE_FRAMES(0), .AUTO_SERVE(0)
  ) dut_manual (
    .i_Clk(clk), .i_Rst(m_rst), .i_VSync(vsync), .i_Game_Start(m_start),
    .i_Ball_X(m_x), .i_Ball_Y(m_y), .i_Paddle_Y_P1(m_pad1), .i_Paddle_Y_P2(m_pad2),
    .o_Game_Active(m_active), .o_P1_Score(m_p1_score), .o_P2_Score(m_p2_score),
    .o_Serve_Dir(m_serve_dir), .o_Point(m_point), .o_Match_Over(m_over), .o_Winner(m_winner)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Rules-level miss test: outside [top, top+PH-1] on the paddle's column, no wrap.
  function automatic bit misses(input int col, input int x, input int y, input int top);
    return (x == col) && ((y < top) || (y > top + PH - 1));
  endfunction

  task automatic check_scores(input string tag);
    chk({tag, "_p1"}, p1_score, exp_p1);
    chk({tag, "_p2"}, p2_score, exp_p2);
  endtask

  // Play FRAMES frame ticks; play must resume right after the last one.
  task automatic serve();
    ball_x = MID_X;
    for (int f = 0; f < FRAMES; f++) begin
      chk("serve_wait_idle", active, 0);
      vsync = 1'b1;
      cycle();
      vsync = 1'b0;
      if (f < FRAMES - 1) begin
        chk("serve_early", active, 0);
        repeat ($urandom_range(1, 3)) cycle();
      end
    end
    chk("serve_go", active, 1);
    cycle();
  endtask

  task automatic restart_match();
    start = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    exp_p1 = 0;
    exp_p2 = 0;
    exp_serve = 1;
    check_scores("restart");
    chk("restart_over", over, 0);
    chk("restart_dir", serve_dir, exp_serve);
    chk("restart_active", active, 0);
    serve();
  endtask

  task automatic rally_vec(input int x, input int y, input int py1, input int py2, input bit st);
    bit m1, m2;
    ball_x = 6'(x); ball_y = 6'(y); pad1 = 6'(py1); pad2 = 6'(py2); start = st;
    cycle();
    m1 = misses(0, x, y, py1);
    m2 = !m1 && misses(GW - 1, x, y, py2);
    if (!m1 && !m2) begin
      chk("rally_active", active, 1);
      chk("rally_no_point", point, 0);
    end else begin
      chk("miss_active_drop", active, 0);
      chk("miss_point_early", point, 0);
      ball_x = MID_X;
      cycle();
      if (m1) begin exp_p2++; exp_serve = 0; end
      else    begin exp_p1++; exp_serve = 1; end
      chk("point_pulse", point, 1);
      check_scores("point");
      chk("point_dir", serve_dir, exp_serve);
      cycle();
      chk("point_end", point, 0);
      if (exp_p1 == LIMIT || exp_p2 == LIMIT) begin
        chk("match_over", over, 1);
        chk("match_winner", winner, (exp_p2 == LIMIT) ? 1 : 0);
        ball_x = 0; ball_y = 63; pad1 = 0;
        vsync = 1'b1; cycle(); vsync = 1'b0; repeat (4) cycle();
        check_scores("frozen");
        chk("frozen_active", active, 0);
        restart_match();
      end else begin
        chk("no_match_over", over, 0);
        serve();
      end
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    repeat (3) cycle();
    exp_p1 = 0; exp_p2 = 0; exp_serve = 1;
    chk("rst_active", active, 0);
    check_scores("rst");
    chk("rst_dir", serve_dir, 1);
    chk("rst_point", point, 0);
    chk("rst_over", over, 0);
    chk("rst_winner", winner, 0);
    rst = 1'b0;
  endtask

  initial begin
    int x, y, py1, py2, mode;
    rst = 1'b1; vsync = 1'b0; start = 1'b0;
    ball_x = MID_X; ball_y = 0; pad1 = 10; pad2 = 10;
    m_rst = 1'b1; m_start = 1'b0; m_x = MID_X; m_y = 0; m_pad1 = 10; m_pad2 = 10;

    reset_all();
    cycle();
    start = 1'b1;
    cycle();
    serve();

    // Paddle boundary rows on both sides, including a paddle hanging off the bottom.
    rally_vec(0, 15, 10, 10, 1);
    rally_vec(0, 10, 10, 10, 0);
    rally_vec(0, 16, 10, 10, 0);
    rally_vec(0,  9, 10, 10, 1);
    rally_vec(GW - 1, 63, 10, 60, 0);
    rally_vec(GW - 1,  9, 10, 10, 0);
    rally_vec(0, 20, 10, 10, 1);

    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 2);
      x   = (mode == 0) ? 0 : (mode == 1) ? GW - 1 : $urandom_range(0, 63);
      py1 = $urandom_range(0, 63);
      py2 = $urandom_range(0, 63);
      case ($urandom_range(0, 3))
        0: y = ((x == 0) ? py1 : py2) + $urandom_range(0, PH - 1);
        1: y = ((x == 0) ? py1 : py2) - 1;
        2: y = ((x == 0) ? py1 : py2) + PH;
        default: y = $urandom_range(0, 63);
      endcase
      y = y & 63;
      rally_vec(x, y, py1, py2, 1'($urandom));
    end

    // Mid-rally reset at 2/1 with start held high and a miss on the wire.
    reset_all();
    start = 1'b1;
    cycle();
    serve();
    rally_vec(GW - 1, 0, 10, 10, 1);
    rally_vec(GW - 1, 0, 10, 10, 1);
    rally_vec(0, 20, 10, 10, 1);
    rst = 1'b1; start = 1'b1; ball_x = 0; ball_y = 40; pad1 = 10;
    cycle();
    exp_p1 = 0; exp_p2 = 0;
    chk("midrst_active", active, 0);
    check_scores("midrst");
    chk("midrst_dir", serve_dir, 1);
    chk("midrst_point", point, 0);
    rst = 1'b0;
    for (int f = 0; f < FRAMES + 1; f++) begin
      vsync = 1'b1; cycle(); vsync = 1'b0; cycle();
    end
    chk("held_start_ignored", active, 0);

    // Manual-serve instance: a point returns to idle until a fresh start edge.
    m_rst = 1'b0;
    cycle();
    m_start = 1'b1;
    cycle();
    chk("m_serve_wait", m_active, 0);
    cycle();
    chk("m_running", m_active, 1);
    m_x = 0; m_y = 20; m_pad1 = 10;
    cycle();
    chk("m_miss_drop", m_active, 0);
    m_x = MID_X;
    cycle();
    chk("m_point", m_point, 1);
    chk("m_p2", m_p2_score, 1);
    chk("m_dir", m_serve_dir, 0);
    for (int f = 0; f < 4; f++) begin
      vsync = 1'b1; cycle(); vsync = 1'b0; cycle();
    end
    chk("m_idle_hold", m_active, 0);
    chk("m_over", m_over, 0);
    m_start = 1'b0;
    cycle();
    m_start = 1'b1;
    cycle();
    cycle();
    chk("m_restart", m_active, 1);
    chk("m_score_kept", m_p2_score, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
